// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the in-place radix-2 DIT FFT butterfly scheduler:
//   - default transform geometry (N, LOG2N, BF_LAT)
//   - scheduler state encoding
//   - bfly_addr(): maps (stage, butterfly index) to the two sample addresses
//     and the twiddle index used by the DFT2 unit.
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int N_DEF      = 8;
    localparam int LOG2N_DEF  = 3;
    localparam int BF_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Full-width result; callers truncate to LOG2N bits.
    typedef struct packed {
        logic [31:0] addr_a;
        logic [31:0] addr_b;
        logic [31:0] tw_idx;
    } bfly_addr_t;

    // Stage s pairs samples that are span = 2^s apart. Butterfly k sits at
    // offset pos inside group grp; each group covers 2*span samples.
    // The twiddle exponent is pos scaled up to the N-point twiddle table.
    // For s > log2n-1 the shift amount wraps and the twiddle becomes 0; such
    // stage values are never issued.
    function automatic bfly_addr_t bfly_addr(input int unsigned log2n,
                                             input int unsigned s,
                                             input int unsigned k);
        int unsigned span;
        int unsigned pos;
        int unsigned grp;
        bfly_addr_t  r;
        span     = 32'd1 << s;
        pos      = k & (span - 32'd1);
        grp      = k >> s;
        r.addr_a = grp * 32'd2 * span + pos;
        r.addr_b = r.addr_a + span;
        r.tw_idx = pos << (log2n - 32'd1 - s);
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_addr_gen
// Purely combinational butterfly address generator.
// Ports:
//   stage   in   LOG2N    FFT stage 0..LOG2N-1
//   k       in   LOG2N-1  butterfly index within the stage 0..N/2-1
//   addr_a  out  LOG2N    upper-leg sample address
//   addr_b  out  LOG2N    lower-leg sample address (addr_a + 2^stage)
//   tw_idx  out  LOG2N    twiddle index for the DFT2 unit
// ---------------------------------------------------------------------------
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic [LOG2N-1:0] stage,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-1:0] tw_idx
);

    bfly_addr_t res;

    always_comb begin
        res    = bfly_addr(LOG2N, 32'(stage), 32'(k));
        addr_a = LOG2N'(res.addr_a);
        addr_b = LOG2N'(res.addr_b);
        tw_idx = LOG2N'(res.tw_idx);
    end

endmodule

// File: rtl/fft_bfly_scheduler.sv
// ---------------------------------------------------------------------------
// fft_bfly_scheduler
// Sequences an in-place N-point radix-2 DIT FFT through a single shared DFT2
// butterfly: N/2 butterflies per stage, LOG2N stages, a BF_LAT-cycle drain
// between stages so that a stage never reads a sample before the previous
// stage's write to it has landed.
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset (aborts, no done)
//   start               transform request, sampled only while idle
//   busy                high while butterflies are issued or draining
//   done                one-cycle pulse after the last write-back
//   stage               current stage
//   bf_valid            a butterfly is issued this cycle
//   rd_addr_a/rd_addr_b sample RAM read addresses for the butterfly
//   tw_idx              twiddle index for the DFT2, valid with bf_valid
//   wr_en               write the DFT2 results back
//   wr_addr_a/wr_addr_b write addresses (read addresses delayed BF_LAT)
// ---------------------------------------------------------------------------
module fft_bfly_scheduler
    import fft_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int LOG2N  = LOG2N_DEF,
    parameter int BF_LAT = BF_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] stage,
    output logic             bf_valid,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-1:0] tw_idx,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b
);

    localparam int KW = LOG2N - 1;
    localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam int WW = 1 + 2 * LOG2N;

    localparam logic [KW-1:0]    K_LAST = KW'(N / 2 - 1);
    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(BF_LAT - 1);

    state_t           state_reg;
    logic [KW-1:0]    k_reg;
    logic [LOG2N-1:0] stage_reg;
    logic [DW-1:0]    drain_reg;

    // Address generator looks one butterfly ahead so the read address,
    // twiddle and bf_valid can all be registered together.
    logic [LOG2N-1:0] gen_stage;
    logic [KW-1:0]    gen_k;
    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [LOG2N-1:0] gen_tw;

    always_comb begin
        gen_stage = '0;
        gen_k     = '0;
        case (state_reg)
            RUN: begin
                gen_stage = stage_reg;
                gen_k     = k_reg + 1'b1;
            end
            DRAIN: begin
                gen_stage = stage_reg + 1'b1;
                gen_k     = '0;
            end
            default: begin
                gen_stage = '0;
                gen_k     = '0;
            end
        endcase
    end

    fft_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .stage  (gen_stage),
        .k      (gen_k),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            stage_reg <= '0;
            drain_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bf_valid  <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                        k_reg     <= '0;
                        stage_reg <= '0;
                        busy      <= 1'b1;
                        bf_valid  <= 1'b1;
                        rd_addr_a <= gen_a;
                        rd_addr_b <= gen_b;
                        tw_idx    <= gen_tw;
                    end
                end
                RUN: begin
                    if (k_reg == K_LAST) begin
                        state_reg <= DRAIN;
                        k_reg     <= '0;
                        drain_reg <= '0;
                        bf_valid  <= 1'b0;
                    end else begin
                        k_reg     <= k_reg + 1'b1;
                        rd_addr_a <= gen_a;
                        rd_addr_b <= gen_b;
                        tw_idx    <= gen_tw;
                    end
                end
                DRAIN: begin
                    if (drain_reg == D_LAST) begin
                        drain_reg <= '0;
                        if (stage_reg == S_LAST) begin
                            state_reg <= DONE;
                            stage_reg <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            stage_reg <= stage_reg + 1'b1;
                            bf_valid  <= 1'b1;
                            rd_addr_a <= gen_a;
                            rd_addr_b <= gen_b;
                            tw_idx    <= gen_tw;
                        end
                    end else begin
                        drain_reg <= drain_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign stage = stage_reg;

    // Write-back delay line: tap 0 captures the issued butterfly, the last
    // tap lines up with the DFT2 result BF_LAT cycles later.
    for (genvar gi = 0; gi < BF_LAT; gi++) begin : g_dly
        logic [WW-1:0] tap_reg;
        if (gi == 0) begin : g_head
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tap_reg <= '0;
                end else begin
                    tap_reg <= {bf_valid, rd_addr_a, rd_addr_b};
                end
            end
        end else begin : g_body
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tap_reg <= '0;
                end else begin
                    tap_reg <= g_dly[gi-1].tap_reg;
                end
            end
        end
    end

    assign {wr_en, wr_addr_a, wr_addr_b} = g_dly[BF_LAT-1].tap_reg;

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fft_bfly_scheduler
// Three scheduler instances (N=8/BF_LAT=1, N=8/BF_LAT=3, N=16/BF_LAT=1) share
// clock, reset and start. A per-instance reference model tracks the elapsed
// cycle count of an accepted transform and derives every expected output
// from it arithmetically; a write-count scoreboard checks RAW ordering and
// that every address is written once per stage.
// ---------------------------------------------------------------------------
module tb_fft_bfly_scheduler;

    localparam int NC = 3;
    localparam int N_T   [NC] = '{8, 8, 16};
    localparam int LG_T  [NC] = '{3, 3, 4};
    localparam int LAT_T [NC] = '{1, 3, 1};

    logic clk = 1'b0;
    logic rst;
    logic start;

    logic       busy_o  [NC];
    logic       done_o  [NC];
    logic       bfv_o   [NC];
    logic       wre_o   [NC];
    logic [3:0] stage_o [NC];
    logic [3:0] ra_o    [NC];
    logic [3:0] rb_o    [NC];
    logic [3:0] tw_o    [NC];
    logic [3:0] wa_o    [NC];
    logic [3:0] wb_o    [NC];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NC; gi++) begin : g_dut
        localparam int NN = N_T[gi];
        localparam int LG = LG_T[gi];
        localparam int LT = LAT_T[gi];
        logic          bs, dn, bv, we;
        logic [LG-1:0] st, ra, rb, tw, wa, wb;

        fft_bfly_scheduler #(
            .N      (NN),
            .LOG2N  (LG),
            .BF_LAT (LT)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .busy      (bs),
            .done      (dn),
            .stage     (st),
            .bf_valid  (bv),
            .rd_addr_a (ra),
            .rd_addr_b (rb),
            .tw_idx    (tw),
            .wr_en     (we),
            .wr_addr_a (wa),
            .wr_addr_b (wb)
        );

        assign busy_o[gi]  = bs;
        assign done_o[gi]  = dn;
        assign bfv_o[gi]   = bv;
        assign wre_o[gi]   = we;
        assign stage_o[gi] = 4'(st);
        assign ra_o[gi]    = 4'(ra);
        assign rb_o[gi]    = 4'(rb);
        assign tw_o[gi]    = 4'(tw);
        assign wa_o[gi]    = 4'(wa);
        assign wb_o[gi]    = 4'(wb);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected butterfly geometry straight from the stage/span definition.
    task automatic ref_bfly(input int lg, input int s, input int k,
                            output int a, output int b, output int tw);
        int span;
        span = 1 << s;
        a    = (k / span) * 2 * span + (k % span);
        b    = a + span;
        tw   = (k % span) * (1 << (lg - 1 - s));
    endtask

    // Hand-written N=8 schedule, index = stage*4 + k.
    int tab_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int tab_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int tab_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    // Model: ph = -1 idle, 0..total-1 busy cycle index, total = done cycle.
    int ph       [NC];
    int accepted [NC];
    int dones    [NC];
    int wcnt     [NC][16];
    int cyc = 0;

    task automatic check_cycle(input int c);
        int n, lg, lat, L, total, p, q, s, r;
        int e_busy, e_done, e_bv, e_st, e_we;
        int a, b, tw;
        string id;
        n     = N_T[c];
        lg    = LG_T[c];
        lat   = LAT_T[c];
        L     = n / 2 + lat;
        total = lg * L;
        p     = ph[c];
        id    = $sformatf("c%0d.cyc%0d", c, cyc);

        e_busy = (p >= 0 && p < total) ? 1 : 0;
        e_done = (p == total) ? 1 : 0;
        e_bv   = 0;
        e_st   = 0;
        s      = 0;
        r      = 0;
        if (e_busy != 0) begin
            s    = p / L;
            r    = p % L;
            e_st = s;
            e_bv = (r < n / 2) ? 1 : 0;
        end
        chk({id, ".busy"},     int'(busy_o[c]),  e_busy);
        chk({id, ".done"},     int'(done_o[c]),  e_done);
        chk({id, ".bf_valid"}, int'(bfv_o[c]),   e_bv);
        chk({id, ".stage"},    int'(stage_o[c]), e_st);

        if (e_bv != 0) begin
            ref_bfly(lg, s, r, a, b, tw);
            chk({id, ".rd_a"}, int'(ra_o[c]), a);
            chk({id, ".rd_b"}, int'(rb_o[c]), b);
            chk({id, ".tw"},   int'(tw_o[c]), tw);
            if (c == 0) begin
                chk({id, ".tab_a"},  int'(ra_o[c]), tab_a[s * 4 + r]);
                chk({id, ".tab_b"},  int'(rb_o[c]), tab_b[s * 4 + r]);
                chk({id, ".tab_tw"}, int'(tw_o[c]), tab_tw[s * 4 + r]);
            end
            // Every earlier stage must have written this sample already.
            chk({id, ".raw_a"}, wcnt[c][ra_o[c]], s);
            chk({id, ".raw_b"}, wcnt[c][rb_o[c]], s);
        end

        q    = p - lat;
        e_we = (p >= 0 && q >= 0 && q < total && (q % L) < n / 2) ? 1 : 0;
        chk({id, ".wr_en"}, int'(wre_o[c]), e_we);
        if (e_we != 0) begin
            ref_bfly(lg, q / L, q % L, a, b, tw);
            chk({id, ".wr_a"}, int'(wa_o[c]), a);
            chk({id, ".wr_b"}, int'(wb_o[c]), b);
        end
        if (wre_o[c]) begin
            wcnt[c][wa_o[c]]++;
            wcnt[c][wb_o[c]]++;
        end

        if (done_o[c]) dones[c]++;
        if (e_done != 0) begin
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s.wcount%0d", id, i), wcnt[c][i], lg);
            end
            $display("cfg%0d N=%0d BF_LAT=%0d transform %0d complete at cycle %0d",
                     c, n, lat, accepted[c], cyc);
        end
    endtask

    initial begin
        for (int c = 0; c < NC; c++) begin
            ph[c]       = -1;
            accepted[c] = 0;
            dones[c]    = 0;
            for (int i = 0; i < 16; i++) wcnt[c][i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int c = 0; c < NC; c++) begin
                int total;
                total = LG_T[c] * (N_T[c] / 2 + LAT_T[c]);
                if (rst) begin
                    if (ph[c] >= 0 && ph[c] < total) accepted[c]--;
                    ph[c] = -1;
                end else if (ph[c] < 0) begin
                    if (start) begin
                        ph[c] = 0;
                        accepted[c]++;
                        for (int i = 0; i < 16; i++) wcnt[c][i] = 0;
                    end
                end else if (ph[c] == total) begin
                    ph[c] = -1;
                end else begin
                    ph[c]++;
                end
            end
            #1;
            for (int c = 0; c < NC; c++) check_cycle(c);
        end
    end

    initial begin
        int hold;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Start, then reset while config 0 is at stage 1, k=2.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        chk("pre_rst.stage", int'(stage_o[0]), 1);
        chk("pre_rst.rd_a",  int'(ra_o[0]), 4);
        rst = 1'b1;
        #1;
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("c%0d.rst.busy", c),  int'(busy_o[c]), 0);
            chk($sformatf("c%0d.rst.done", c),  int'(done_o[c]), 0);
            chk($sformatf("c%0d.rst.stage", c), int'(stage_o[c]), 0);
            chk($sformatf("c%0d.rst.bfv", c),   int'(bfv_o[c]), 0);
            chk($sformatf("c%0d.rst.rd_a", c),  int'(ra_o[c]), 0);
            chk($sformatf("c%0d.rst.rd_b", c),  int'(rb_o[c]), 0);
            chk($sformatf("c%0d.rst.tw", c),    int'(tw_o[c]), 0);
            chk($sformatf("c%0d.rst.wr_en", c), int'(wre_o[c]), 0);
            chk($sformatf("c%0d.rst.wr_a", c),  int'(wa_o[c]), 0);
            chk($sformatf("c%0d.rst.wr_b", c),  int'(wb_o[c]), 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Start held high first, then random pulses (many land mid-transform).
        hold = 80;
        for (int i = 0; i < 900; i++) begin
            if (hold > 0) begin
                start = 1'b1;
                hold--;
            end else begin
                start = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 99) == 0) hold = $urandom_range(20, 60);
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (60) @(negedge clk);

        for (int c = 0; c < NC; c++) begin
            chk($sformatf("c%0d.done_count", c), dones[c], accepted[c]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
